// File: rtl/spi_master.sv
// SPI mode-0 byte shifter, MSB first; spi_txn_done is low for exactly 16*CLK_DIV cycles.
// Backpressure: spi_txn_start is only honoured in IDLE; inputs are ignored during SHIFT.
module spi_master #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] spi_data_tx,
  input  logic       spi_txn_start,
  output logic [7:0] spi_data_rx,
  output logic       spi_txn_done,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [0:0]    state;
  logic [DW-1:0] div_cnt;
  logic [4:0]    tog_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          div_tc;

  assign div_tc = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      tog_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      spi_txn_done <= 1'b1;
      spi_data_rx  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (spi_txn_start) begin
            tx_sr        <= spi_data_tx;
            spi_mosi     <= spi_data_tx[7];
            spi_txn_done <= 1'b0;
            div_cnt      <= '0;
            tog_cnt      <= '0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt  <= '0;
            tog_cnt  <= tog_cnt + 5'd1;
            spi_sclk <= ~spi_sclk;
            if (!spi_sclk) begin
              rx_sr <= {rx_sr[6:0], spi_miso};
            end else if (tog_cnt == 5'd15) begin
              // Final falling edge: rx_sr already holds all eight sampled bits.
              spi_data_rx  <= rx_sr;
              spi_txn_done <= 1'b1;
              spi_mosi     <= 1'b0;
              state        <= IDLE;
            end else begin
              spi_mosi <= tx_sr[6];
              tx_sr    <= {tx_sr[6:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master at CLK_DIV=1 and CLK_DIV=3 with a mode-0 slave model and a scoreboard.
module tb_spi_master;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx1, tx3, rx1, rx3;
  logic       start1, start3, done1, done3, sclk1, sclk3, mosi1, mosi3, miso1, miso3;

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi_data_tx(tx1), .spi_txn_start(start1),
    .spi_data_rx(rx1), .spi_txn_done(done1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  spi_master #(.CLK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .spi_data_tx(tx3), .spi_txn_start(start3),
    .spi_data_rx(rx3), .spi_txn_done(done3), .spi_sclk(sclk3), .spi_mosi(mosi3), .spi_miso(miso3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_sclk, m_mosi, m_done;
  logic [7:0] m_rx [2];
  assign m_sclk  = {sclk3, sclk1};
  assign m_mosi  = {mosi3, mosi1};
  assign m_done  = {done3, done1};
  assign m_rx[0] = rx1;
  assign m_rx[1] = rx3;

  // Slave model: presents bit 7 while idle, advances on each falling SCLK.
  logic [7:0] sl_byte [2];
  logic [2:0] sl_cnt [2];
  assign miso1 = sl_byte[0][3'd7 - sl_cnt[0]];
  assign miso3 = sl_byte[1][3'd7 - sl_cnt[1]];

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  logic [7:0] cap [2];
  int         rises [2], tot_rises [2], low_cnt [2], ph_cnt [2], edges [2], hi_cnt [2], done_cnt [2];
  logic       p_sclk [2], p_done [2], b2b [2], b2b_seen [2];
  logic [7:0] p_rx [2];

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        cap[i] = '0; rises[i] = 0; low_cnt[i] = 0; ph_cnt[i] = 0; edges[i] = 0;
        hi_cnt[i] = 0; sl_cnt[i] = '0;
      end else begin
        if (m_sclk[i] != p_sclk[i]) begin
          chk("sclk_phase_len", ph_cnt[i], div_of(i));
          ph_cnt[i] = 0;
          edges[i]++;
          if (m_sclk[i]) begin
            cap[i] = {cap[i][6:0], m_mosi[i]};
            rises[i]++;
            tot_rises[i]++;
          end
        end
        if (m_rx[i] != p_rx[i]) chk("rx_change_only_at_done", {p_done[i], m_done[i]}, 2'b01);
        if (m_done[i]) chk("sclk_low_when_done", m_sclk[i], 1'b0);
        if (!m_done[i] && p_done[i]) begin
          if (b2b[i] && b2b_seen[i]) chk("b2b_idle_gap", hi_cnt[i], 1);
          b2b_seen[i] = b2b[i];
        end
        if (m_done[i] && !p_done[i]) begin
          logic [15:0] e;
          done_cnt[i]++;
          hi_cnt[i] = 0;
          if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            chk("unexpected_transfer", 1, 0);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("mosi_byte", cap[i], e[15:8]);
            chk("data_rx", m_rx[i], e[7:0]);
            chk("done_low_cycles", low_cnt[i], 16 * div_of(i));
            chk("sclk_rises", rises[i], 8);
            chk("mosi_idle", m_mosi[i], 1'b0);
          end
          cap[i] = '0; rises[i] = 0; low_cnt[i] = 0; edges[i] = 0;
        end
        if (m_done[i]) hi_cnt[i]++;
        if (!m_done[i]) begin
          low_cnt[i]++;
          ph_cnt[i]++;
        end
        if (m_done[i]) sl_cnt[i] = '0;
        else if (p_sclk[i] && !m_sclk[i]) sl_cnt[i] = sl_cnt[i] + 3'd1;
      end
      p_sclk[i] = m_sclk[i];
      p_done[i] = m_done[i];
      p_rx[i]   = m_rx[i];
    end
  end

  task automatic wait_done(input int i, input logic val, input int budget, input string tag);
    int n = 0;
    while (m_done[i] !== val && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (m_done[i] !== val) chk(tag, m_done[i], val);
  endtask

  task automatic set_in(input int i, input logic [7:0] tx, input logic st);
    if (i == 0) begin tx1 = tx; start1 = st; end
    else begin tx3 = tx; start3 = st; end
  endtask

  // Upstream handshake: raise start on done=1, drop it on done=0, wait for done=1.
  task automatic xfer(input int i, input logic [7:0] tx, input logic [7:0] sl);
    wait_done(i, 1'b1, 2000, "timeout_ready");
    sl_byte[i] = sl;
    if (i == 0) q0.push_back({tx, sl}); else q1.push_back({tx, sl});
    set_in(i, tx, 1'b1);
    wait_done(i, 1'b0, 10, "timeout_busy");
    set_in(i, tx, 1'b0);
    wait_done(i, 1'b1, 2000, "timeout_done");
  endtask

  initial begin
    int base, n;
    for (int i = 0; i < 2; i++) begin
      sl_byte[i] = 8'h00; tot_rises[i] = 0; done_cnt[i] = 0; b2b[i] = 1'b0; b2b_seen[i] = 1'b0;
    end
    tx1 = 8'h00; tx3 = 8'h00; start1 = 1'b0; start3 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset state, held with no start.
    repeat (20) @(negedge clk);
    #1;
    chk("rst_done1", done1, 1'b1); chk("rst_sclk1", sclk1, 1'b0);
    chk("rst_mosi1", mosi1, 1'b0); chk("rst_rx1", rx1, 8'h00);
    chk("rst_done3", done3, 1'b1); chk("rst_sclk3", sclk3, 1'b0);
    chk("rst_mosi3", mosi3, 1'b0); chk("rst_rx3", rx3, 8'h00);

    // Single byte at CLK_DIV=1.
    xfer(0, 8'h03, 8'hA5);

    // Five-byte handshake sequence.
    base = tot_rises[0];
    xfer(0, 8'h03, 8'hFF);
    xfer(0, 8'h00, 8'hFF);
    xfer(0, 8'h12, 8'hFF);
    xfer(0, 8'h34, 8'hFF);
    xfer(0, 8'h00, 8'h5C);
    chk("seq_total_rises", tot_rises[0] - base, 40);
    chk("seq_final_rx", rx1, 8'h5C);

    // CLK_DIV=3 with input disturbance mid-transfer.
    sl_byte[1] = 8'h42;
    q1.push_back({8'h81, 8'h42});
    set_in(1, 8'h81, 1'b1);
    wait_done(1, 1'b0, 10, "timeout_busy3");
    set_in(1, 8'h81, 1'b0);
    repeat (10) @(negedge clk);
    #1 set_in(1, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    #1 set_in(1, 8'h00, 1'b0);
    wait_done(1, 1'b1, 200, "timeout_done3");
    repeat (20) @(negedge clk);
    #1;
    chk("no_extra_xfer_done3", done3, 1'b1);
    chk("no_extra_xfer_cnt3", done_cnt[1], 1);

    // Back-to-back with start held high.
    b2b[0] = 1'b1;
    sl_byte[0] = 8'h3C;
    for (int k = 0; k < 3; k++) q0.push_back({8'hC3, 8'h3C});
    base = done_cnt[0];
    set_in(0, 8'hC3, 1'b1);
    n = 0;
    while (done_cnt[0] - base < 3 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    set_in(0, 8'hC3, 1'b0);
    chk("b2b_completions", done_cnt[0] - base, 3);
    repeat (20) @(negedge clk);
    #1;
    b2b[0] = 1'b0;
    chk("b2b_rx_hold", rx1, 8'h3C);

    // Reset mid-transfer, then a clean transfer.
    sl_byte[0] = 8'h99;
    q0.push_back({8'hFF, 8'h99});
    set_in(0, 8'hFF, 1'b1);
    wait_done(0, 1'b0, 10, "timeout_busy_rst");
    set_in(0, 8'hFF, 1'b0);
    n = 0;
    while (edges[0] < 5 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_pre_edges", edges[0], 5);
    rst_n = 1'b0;
    #1;
    chk("arst_done", done1, 1'b1); chk("arst_sclk", sclk1, 1'b0);
    chk("arst_mosi", mosi1, 1'b0); chk("arst_rx", rx1, 8'h00);
    q0.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    xfer(0, 8'hB6, 8'h6D);

    repeat (10) @(negedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
